// File: rtl/erase_frame_seq_pkg.sv
// Shared types and constants for the erase_frame_seq pixel-correction sequencer.
// Optional feature macro used by the top level: ERASE_DEAD_CNT_EN.
package erase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ADVANCE,
        GAP,
        FRAME_END
    } state_t;

    // Test-marker window, inclusive bounds
    localparam logic [6:0] MK_X_LO = 7'd39;
    localparam logic [6:0] MK_X_HI = 7'd40;
    localparam logic [5:0] MK_Y_LO = 6'd31;
    localparam logic [5:0] MK_Y_HI = 6'd32;

    // Pixel levels
    localparam logic [9:0] BG_LEVEL  = 10'd10;
    localparam logic [9:0] CLIP_VAL  = 10'd1022;
    localparam logic [9:0] MK_RESET  = 10'd250;
    localparam logic [9:0] MK_STEP   = 10'd50;
    localparam logic [9:0] MK_LIMIT  = 10'd1000;

    // Marker level advances once per frame and wraps back to its reset value
    function automatic logic [9:0] next_level(input logic [9:0] lvl);
        return (lvl >= MK_LIMIT) ? MK_RESET : (lvl + MK_STEP);
    endfunction

endpackage

// File: rtl/erase_frame_seq_pix_dp.sv
// Combinational pixel datapath: overload clip, dead-pixel substitution and
// test-marker overlay. All state lives in the sequencer.
module erase_pix_dp
    import erase_pkg::*;
#(
    parameter int unsigned OVL_THR = 2045
) (
    input  logic [15:0] rd_data,
    input  logic        dp_bit,
    input  logic [9:0]  last_good,
    input  logic        test_q,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic [9:0]  level,
    output logic [9:0]  clip_val,
    output logic [9:0]  pix_val
);

    logic [9:0] dead_val;
    logic       in_mark;

    // Clip, substitute and overlay for the sample currently on the read bus
    always_comb begin
        clip_val = (rd_data >= 16'(OVL_THR)) ? CLIP_VAL : rd_data[10:1];
        dead_val = dp_bit ? last_good : clip_val;
        in_mark  = (x >= MK_X_LO) && (x <= MK_X_HI) &&
                   (y >= MK_Y_LO) && (y <= MK_Y_HI);
        if (test_q) begin
            pix_val = in_mark ? level : BG_LEVEL;
        end else begin
            pix_val = dead_val;
        end
    end

endmodule

// File: rtl/erase_frame_seq.sv
// Frame sequencer: raster-scans a COLS x ROWS frame, fetches raw samples over
// a req/ack handshake and emits a registered 10-bit corrected pixel stream.
// Define ERASE_DEAD_CNT_EN to add the per-frame dead-pixel count output.
module erase_frame_seq
    import erase_pkg::*;
#(
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 64,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned OVL_THR = 2045
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        test,
    output logic        rd_req,
    output logic [12:0] rd_addr,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    input  logic        dp_bit,
    output logic        pix_valid,
    output logic [9:0]  pix_data,
    output logic [6:0]  pix_x,
    output logic [5:0]  pix_y,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
`ifdef ERASE_DEAD_CNT_EN
   ,output logic [12:0] dead_cnt
`endif
);

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [5:0] Y_LAST = 6'(ROWS - 1);
    localparam int unsigned GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

    state_t        state;
    logic [6:0]    x;
    logic [5:0]    y;
    logic [GW-1:0] gap_cnt;
    logic          test_q;
    logic [9:0]    last_good;
    logic [9:0]    level;
    logic [9:0]    clip_val;
    logic [9:0]    pix_val;

    assign rd_addr = {y, x};

    erase_pix_dp #(
        .OVL_THR (OVL_THR)
    ) u_pix_dp (
        .rd_data   (rd_data),
        .dp_bit    (dp_bit),
        .last_good (last_good),
        .test_q    (test_q),
        .x         (x),
        .y         (y),
        .level     (level),
        .clip_val  (clip_val),
        .pix_val   (pix_val)
    );

    // Raster-scan sequencer with registered request and pixel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            gap_cnt    <= '0;
            test_q     <= 1'b0;
            last_good  <= '0;
            level      <= MK_RESET;
            rd_req     <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start && busy) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (frame_start && enable) begin
                        x         <= '0;
                        y         <= '0;
                        test_q    <= test;
                        last_good <= '0;
                        busy      <= 1'b1;
                        rd_req    <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_ack) begin
                        rd_req    <= 1'b0;
                        pix_valid <= 1'b1;
                        pix_data  <= pix_val;
                        pix_x     <= x;
                        pix_y     <= y;
                        if (!dp_bit) begin
                            last_good <= clip_val;
                        end
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (x < X_LAST) begin
                        x      <= x + 7'd1;
                        rd_req <= 1'b1;
                        state  <= FETCH;
                    end else if (y < Y_LAST) begin
                        x       <= '0;
                        y       <= y + 6'd1;
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        frame_done <= 1'b1;
                        state      <= FRAME_END;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        rd_req <= 1'b1;
                        state  <= FETCH;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                FRAME_END: begin
                    busy  <= 1'b0;
                    level <= next_level(level);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ERASE_DEAD_CNT_EN
    logic [12:0] dead_acc;

    // Accumulate dead-map hits over a frame and publish the total at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            dead_acc <= '0;
            dead_cnt <= '0;
        end else begin
            if (state == IDLE && frame_start && enable) begin
                dead_acc <= '0;
            end else if (state == FETCH && rd_ack && dp_bit && dead_acc != '1) begin
                dead_acc <= dead_acc + 13'd1;
            end
            if (state == FRAME_END) begin
                dead_cnt <= dead_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_erase_frame_seq.sv
// Scoreboard bench for erase_frame_seq. The memory responder pushes the
// hand-computed expected pixel when it acks; a monitor pops on pix_valid.
module tb_erase_frame_seq;

    localparam int COLS = 41;
    localparam int ROWS = 33;
    localparam int GAPC = 4;

    logic        clk = 1'b0;
    logic        rst, enable, frame_start, test;
    logic        rd_req, rd_ack, dp_bit;
    logic [12:0] rd_addr;
    logic [15:0] rd_data;
    logic        pix_valid, busy, frame_done, overrun;
    logic [9:0]  pix_data;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
`ifdef ERASE_DEAD_CNT_EN
    logic [12:0] dead_cnt;
`endif

    erase_frame_seq #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .GAP_CYC (GAPC),
        .OVL_THR (2045)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .test        (test),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .dp_bit      (dp_bit),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
`ifdef ERASE_DEAD_CNT_EN
       ,.dead_cnt    (dead_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] sp_data[int];
    logic        sp_dp[int];
    int          sp_exp[int];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int pix_cnt  = 0;
    int f_id     = 0;
    int t_row0   = 0;
    int t_row1   = 0;
    bit f_test   = 1'b0;
    int f_level  = 250;
    int ack_lat  = 0;
    bit resp_en  = 1'b1;
    bit stale_ack = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after ack_lat wait cycles and queues the expectation
    initial begin
        int   wcnt;
        int   a;
        exp_t e;
        wcnt = 0;
        rd_ack = 1'b0;
        rd_data = '0;
        dp_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                wcnt = 0;
                rd_ack = stale_ack;
                rd_data = 16'h0400;
                dp_bit = 1'b0;
                continue;
            end
            rd_ack = 1'b0;
            if (rd_req) begin
                if (wcnt >= ack_lat) begin
                    a = int'(rd_addr);
                    e.x = a % 128;
                    e.y = a / 128;
                    if (sp_data.exists(a)) begin
                        rd_data = sp_data[a];
                        dp_bit  = sp_dp[a];
                        e.d     = sp_exp[a];
                    end else begin
                        rd_data = 16'h0400;
                        dp_bit  = 1'b0;
                        if (f_test)
                            e.d = (e.x >= 39 && e.x <= 40 && e.y >= 31 && e.y <= 32) ? f_level : 10;
                        else
                            e.d = 512;
                    end
                    rd_ack = 1'b1;
                    sb_q.push_back(e);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: compares every output pixel against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) done_cnt++;
        if (pix_valid) begin
            pix_cnt++;
            if (f_id == 3 && pix_x == 7'd40 && pix_y == 6'd0) t_row0 = cyc;
            if (f_id == 3 && pix_x == 7'd0 && pix_y == 6'd1) t_row1 = cyc;
            if (sb_q.size() == 0) begin
                check("spurious_pix_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("pix_data(%0d,%0d)", e.x, e.y), int'(pix_data), e.d);
                check($sformatf("pix_xy(%0d,%0d)", e.x, e.y),
                      int'(pix_y) * 128 + int'(pix_x), e.y * 128 + e.x);
            end
        end
    end

    task automatic add_sp(input int x, input int y, input logic [15:0] d,
                          input logic dp, input int ex);
        sp_data[y * 128 + x] = d;
        sp_dp[y * 128 + x]   = dp;
        sp_exp[y * 128 + x]  = ex;
    endtask

    task automatic run_frame(input int id, input bit t, input int lvl,
                             input int lat, input bit poke, input bit drop_en);
        int d0;
        f_id = id;
        f_test = t;
        f_level = lvl;
        ack_lat = lat;
        @(negedge clk);
        d0 = done_cnt;
        test = t;
        enable = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        test = 1'b0;
        check($sformatf("busy_on_accept_f%0d", id), int'(busy), 1);
        repeat (60) @(negedge clk);
        if (poke) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        if (drop_en) enable = 1'b0;
        for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
        check($sformatf("frame_done_f%0d", id), done_cnt - d0, 1);
        repeat (2) @(negedge clk);
        check($sformatf("busy_low_f%0d", id), int'(busy), 0);
        check($sformatf("single_done_f%0d", id), done_cnt - d0, 1);
        check($sformatf("sb_empty_f%0d", id), sb_q.size(), 0);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        enable = 1'b0;
        frame_start = 1'b0;
        test = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_req", int'(rd_req), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_pix_xy", int'({pix_y, pix_x}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // frame_start without enable is dropped
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (10) @(negedge clk);
        check("noen_busy", int'(busy), 0);
        check("noen_rd_req", int'(rd_req), 0);
        check("noen_overrun", int'(overrun), 0);

        // Test-pattern frames: marker 250 then 300
        run_frame(1, 1'b1, 250, 0, 1'b0, 1'b0);
        run_frame(2, 1'b1, 300, 0, 1'b0, 1'b0);

        // Normal frame with clip / dead-pixel vectors, 1-cycle ack latency
        add_sp(0, 0, 16'h0400, 1'b1, 0);      // dead first pixel -> cleared last_good
        add_sp(5, 0, 16'd600, 1'b0, 300);
        add_sp(6, 0, 16'd900, 1'b1, 300);
        add_sp(10, 0, 16'd2044, 1'b0, 1022);
        add_sp(11, 0, 16'd2045, 1'b0, 1022);
        add_sp(12, 0, 16'hFFFF, 1'b0, 1022);
        add_sp(13, 0, 16'd2043, 1'b0, 1021);
        add_sp(20, 1, 16'h1234, 1'b1, 512);
        run_frame(3, 1'b0, 0, 1, 1'b1, 1'b0);
        check("overrun_set", int'(overrun), 1);
        check("row_gap_cycles", t_row1 - t_row0, 3 + GAPC);
`ifdef ERASE_DEAD_CNT_EN
        check("dead_cnt_f3", int'(dead_cnt), 3);
`endif
        sp_data.delete();
        sp_dp.delete();
        sp_exp.delete();

        // Plain frames to walk the marker level up to 1000; enable drops mid-frame in f4
        run_frame(4, 1'b0, 0, 0, 1'b0, 1'b1);
        check("enable_low_no_restart", int'(busy), 0);
`ifdef ERASE_DEAD_CNT_EN
        check("dead_cnt_f4", int'(dead_cnt), 0);
`endif
        for (int f = 5; f <= 15; f++) run_frame(f, 1'b0, 0, 0, 1'b0, 1'b0);
        run_frame(16, 1'b1, 1000, 0, 1'b0, 1'b0);
        run_frame(17, 1'b1, 250, 0, 1'b0, 1'b0);

        // Reset during FETCH, then a stale ack while idle
        resp_en = 1'b0;
        f_id = 18;
        @(negedge clk);
        enable = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 50 && !rd_req; i++) @(negedge clk);
        check("fetch_req_pending", int'(rd_req), 1);
        p0 = pix_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        stale_ack = 1'b1;
        @(negedge clk);
        stale_ack = 1'b0;
        repeat (8) @(negedge clk);
        check("stale_ack_no_pix", pix_cnt - p0, 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_rd_req", int'(rd_req), 0);
        check("post_rst_overrun", int'(overrun), 0);
`ifdef ERASE_DEAD_CNT_EN
        check("post_rst_dead_cnt", int'(dead_cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
